// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-mode selector and pointer sizing.
package fifo_pkg;

    // FIFO_FWFT shows the head word combinationally; FIFO_STD registers it on a pop.
    typedef enum logic {
        FIFO_FWFT = 1'b0,
        FIFO_STD  = 1'b1
    } fifo_mode_e;

    // Pointer width able to index entries 0..depth-1 (at least one bit).
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_ptr_mod.sv
// Modulo-DEPTH pointer counter with increment and synchronous clear.
module fifo_ptr_mod
    import fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PW    = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Clear wins over increment; the last index wraps back to zero.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + ONE;
        end
    end

    // Pointer register, returned to entry 0 by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ff_sync_p.sv
// Synchronous flip-flop FIFO with show-ahead or registered read, status flags
// derived from a registered occupancy count, and sticky overflow/underflow.
module fifo_ff_sync_p
    import fifo_pkg::*;
#(
    parameter int         WIDTH     = 32,
    parameter int         DEPTH     = 16,
    parameter int         AF_THRESH = DEPTH - 2,
    parameter int         AE_THRESH = 2,
    parameter fifo_mode_e MODE      = FIFO_FWFT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    input  logic                       err_clr,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH+1)-1:0] occup,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = ptr_width(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    localparam logic [OW-1:0] DEPTH_L = OW'(DEPTH);
    localparam logic [OW-1:0] AF_L    = OW'(AF_THRESH);
    localparam logic [OW-1:0] AE_L    = OW'(AE_THRESH);
    localparam logic [OW-1:0] ONE_O   = OW'(1);

    if (WIDTH < 1 || DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
        AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_params
        $error("fifo_ff_sync_p: illegal WIDTH/DEPTH/AF_THRESH/AE_THRESH combination");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic [OW-1:0] occup_q, occup_d;
    logic empty_q, full_q, ae_q, af_q;
    logic ovf_q, ovf_d, unf_q, unf_d;
    logic rd_acc, wr_acc;

    // A full FIFO still takes a write when the head is popped in the same cycle.
    assign rd_acc = rd_en && !flush && !empty_q;
    assign wr_acc = wr_en && !flush && (!full_q || rd_acc);

    fifo_ptr_mod #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush),
        .inc_i (wr_acc),
        .ptr_o (wr_ptr)
    );

    fifo_ptr_mod #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (flush),
        .inc_i (rd_acc),
        .ptr_o (rd_ptr)
    );

    // Storage is left unreset; empty guards against reading stale entries.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr] <= wr_data;
        end
    end

    // Next occupancy and sticky errors; a new error beats a same-cycle clear.
    always_comb begin
        occup_d = occup_q;
        if (flush) begin
            occup_d = '0;
        end else if (wr_acc && !rd_acc) begin
            occup_d = occup_q + ONE_O;
        end else if (rd_acc && !wr_acc) begin
            occup_d = occup_q - ONE_O;
        end
        ovf_d = ovf_q;
        if (wr_en && !wr_acc && !flush) begin
            ovf_d = 1'b1;
        end else if (err_clr) begin
            ovf_d = 1'b0;
        end
        unf_d = unf_q;
        if (rd_en && !rd_acc && !flush) begin
            unf_d = 1'b1;
        end else if (err_clr) begin
            unf_d = 1'b0;
        end
    end

    // Count, flags and error bits are registered together so they always agree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occup_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            occup_q <= occup_d;
            empty_q <= (occup_d == '0);
            full_q  <= (occup_d == DEPTH_L);
            ae_q    <= (occup_d <= AE_L);
            af_q    <= (occup_d >= AF_L);
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    if (MODE == FIFO_STD) begin : g_std
        logic [WIDTH-1:0] rd_data_q;
        logic             rd_valid_q;

        // Popped word is captured at the edge; valid pulses for that single cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= mem_q[rd_ptr];
                end
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end else begin : g_fwft
        assign rd_data  = mem_q[rd_ptr];
        assign rd_valid = !empty_q;
    end

    assign occup        = occup_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_ff_sync_p.sv
// Bench for fifo_ff_sync_p: a show-ahead and a registered-read instance share the
// same stimulus and are compared every cycle against a queue-based reference.
module tb_fifo_ff_sync_p;
    import fifo_pkg::*;

    localparam int W  = 8;
    localparam int D  = 5;
    localparam int AF = D - 2;
    localparam int AE = 2;
    localparam int OW = $clog2(D + 1);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic         err_clr = 1'b0;
    logic [W-1:0] wr_data = '0;

    logic [W-1:0]  f_rd_data, s_rd_data;
    logic          f_rd_valid, s_rd_valid;
    logic          f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
    logic          s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
    logic [OW-1:0] f_occup, s_occup;

    always #5 clk = ~clk;

    fifo_ff_sync_p #(.WIDTH(W), .DEPTH(D), .MODE(FIFO_FWFT)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .err_clr(err_clr), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .empty(f_empty), .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
        .occup(f_occup), .overflow(f_ovf), .underflow(f_unf)
    );

    fifo_ff_sync_p #(.WIDTH(W), .DEPTH(D), .MODE(FIFO_STD)) u_std (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .err_clr(err_clr), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
        .empty(s_empty), .full(s_full), .almost_empty(s_ae), .almost_full(s_af),
        .occup(s_occup), .overflow(s_ovf), .underflow(s_unf)
    );

    // Reference: contents as a queue, sticky bits, and the registered-read output.
    logic [W-1:0] mq[$];
    bit           m_ovf, m_unf, m_sv;
    logic [W-1:0] m_sd;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 0;
        m_unf = 0;
        m_sv  = 0;
        m_sd  = '0;
    endtask

    task automatic model_cycle();
        bit ra, wa;
        ra = rd_en && !flush && (mq.size() > 0);
        wa = wr_en && !flush && ((mq.size() < D) || ra);
        if (wr_en && !wa && !flush) m_ovf = 1;
        else if (err_clr)           m_ovf = 0;
        if (rd_en && !ra && !flush) m_unf = 1;
        else if (err_clr)           m_unf = 0;
        if (flush) begin
            mq.delete();
            m_sv = 0;
        end else begin
            m_sv = ra;
            if (ra) m_sd = mq.pop_front();
            if (wa) mq.push_back(wr_data);
        end
    endtask

    task automatic check_all();
        int occ;
        occ = mq.size();
        check("f_occup", 32'(f_occup), occ);
        check("s_occup", 32'(s_occup), occ);
        check("f_empty", 32'(f_empty), 32'(occ == 0));
        check("s_empty", 32'(s_empty), 32'(occ == 0));
        check("f_full", 32'(f_full), 32'(occ == D));
        check("s_full", 32'(s_full), 32'(occ == D));
        check("f_almost_full", 32'(f_af), 32'(occ >= AF));
        check("s_almost_full", 32'(s_af), 32'(occ >= AF));
        check("f_almost_empty", 32'(f_ae), 32'(occ <= AE));
        check("s_almost_empty", 32'(s_ae), 32'(occ <= AE));
        check("f_overflow", 32'(f_ovf), 32'(m_ovf));
        check("s_overflow", 32'(s_ovf), 32'(m_ovf));
        check("f_underflow", 32'(f_unf), 32'(m_unf));
        check("s_underflow", 32'(s_unf), 32'(m_unf));
        check("f_rd_valid", 32'(f_rd_valid), 32'(occ != 0));
        if (occ != 0) check("f_rd_data", 32'(f_rd_data), 32'(mq[0]));
        check("s_rd_valid", 32'(s_rd_valid), 32'(m_sv));
        check("s_rd_data", 32'(s_rd_data), 32'(m_sd));
    endtask

    task automatic step(input bit w, input logic [W-1:0] d, input bit r,
                        input bit f = 0, input bit e = 0);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = f;
        err_clr = e;
        model_cycle();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, overflow, then drain in order.
        for (int i = 0; i < 5; i++) begin
            step(1, W'(8'hA0 + i), 0);
            if (i == 2) check("af_at_occup3", 32'(f_af), 32'd1);
        end
        check("full_at_5", 32'(f_full), 32'd1);
        step(1, 8'hA5, 0);
        check("overflow_6th", 32'(f_ovf), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("fwft_order", 32'(f_rd_data), 32'(8'hA0 + i));
            step(0, 8'h00, 1);
            check("std_order", 32'(s_rd_data), 32'(8'hA0 + i));
        end
        check("empty_after_drain", 32'(f_empty), 32'd1);
        step(0, 8'h00, 0, 0, 1);

        // Full FIFO with simultaneous write and read across the pointer wrap.
        for (int i = 0; i < 5; i++) step(1, W'(8'hB0 + i), 0);
        for (int i = 0; i < 7; i++) step(1, W'(8'hC0 + i), 1);
        check("wrap_occup", 32'(f_occup), 32'd5);
        check("wrap_no_ovf", 32'(f_ovf), 32'd0);
        check("wrap_head", 32'(f_rd_data), 32'h000000C2);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1);

        // Registered read latency, hold, and underflow.
        step(1, 8'h55, 0);
        step(0, 8'h00, 1);
        check("std_valid_pulse", 32'(s_rd_valid), 32'd1);
        check("std_data_55", 32'(s_rd_data), 32'h55);
        step(0, 8'h00, 0);
        check("std_valid_drop", 32'(s_rd_valid), 32'd0);
        step(0, 8'h00, 1);
        check("underflow_set", 32'(s_unf), 32'd1);
        check("underflow_no_valid", 32'(s_rd_valid), 32'd0);

        // Flush beats a same-cycle write and read.
        step(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, W'(8'hD0 + i), 0);
        step(1, 8'hEE, 1, 1, 0);
        check("flush_occup", 32'(f_occup), 32'd0);
        check("flush_empty", 32'(f_empty), 32'd1);
        check("flush_no_ovf", 32'(f_ovf), 32'd0);
        check("flush_std_valid", 32'(s_rd_valid), 32'd0);
        step(1, 8'h77, 0);
        check("post_flush_head", 32'(f_rd_data), 32'h77);
        step(0, 8'h00, 1);
        check("post_flush_std", 32'(s_rd_data), 32'h77);

        // Set beats clear, clear alone takes effect.
        for (int i = 0; i < 5; i++) step(1, W'(8'h10 + i), 0);
        step(1, 8'h20, 0);
        step(1, 8'h21, 0, 0, 1);
        check("ovf_set_wins", 32'(f_ovf), 32'd1);
        step(0, 8'h00, 0, 0, 1);
        check("ovf_cleared", 32'(f_ovf), 32'd0);

        // Asynchronous reset between edges with four entries present.
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1);
        for (int i = 0; i < 4; i++) step(1, W'(8'hE0 + i), 0);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("async_rst_occup", 32'(s_occup), 32'd0);
        check("async_rst_empty", 32'(f_empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 8'h3C, 0);
        check("post_rst_head", 32'(f_rd_data), 32'h3C);
        step(0, 8'h00, 1);
        check("post_rst_std", 32'(s_rd_data), 32'h3C);

        // Randomized traffic against the reference.
        repeat (400) begin
            step(($urandom % 10) < 6, W'($urandom), ($urandom % 2) == 1,
                 ($urandom % 32) == 0, ($urandom % 16) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_ff_sync_p.md
FIFO_FF_SYNC_P -- requirements
Module: fifo_ff_sync_p

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data width in bits (legal range >= 1).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the entry count (>= 2); it need not be a power of two.
REQ-003 The block SHALL have parameter AF_THRESH, default DEPTH-2, meaning the almost-full level (1..DEPTH).
REQ-004 The block SHALL have parameter AE_THRESH, default 2, meaning the almost-empty level (0..DEPTH-1).
REQ-005 The block SHALL have parameter MODE, default FIFO_FWFT, meaning the read mode (FIFO_FWFT show-ahead or FIFO_STD registered).
REQ-006 The ports SHALL be: clk  in  1  sole clock; all state on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 flush  in  1  synchronous empty request.
REQ-009 wr_en  in  1  write request; wr_data  in  WIDTH  write data.
REQ-010 rd_en  in  1  read/pop request.
REQ-011 err_clr  in  1  clears the sticky error flags.
REQ-012 rd_data  out  WIDTH  read data; rd_valid  out  1  rd_data qualifier.
REQ-013 empty, full, almost_empty, almost_full  out  1 each  status flags.
REQ-014 occup  out  $clog2(DEPTH+1)  current entry count.
REQ-015 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-016 Write acceptance SHALL be wr_acc = wr_en && !flush && (!full || rd_acc); a write while full is accepted only together with an accepted read.
REQ-017 Read acceptance SHALL be rd_acc = rd_en && !flush && !empty; there is no write-to-read bypass when empty.
REQ-018 Write and read pointers SHALL advance by one on acceptance and wrap from DEPTH-1 to 0.
REQ-019 occup SHALL be registered: +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-020 All status flags SHALL be registered and consistent with occup in the same cycle: empty=(occup==0), full=(occup==DEPTH), almost_full=(occup>=AF_THRESH), almost_empty=(occup<=AE_THRESH).
REQ-021 In FIFO_FWFT mode, rd_data SHALL equal the entry at the read pointer, combinationally, and rd_valid SHALL equal !empty; rd_en pops the displayed word.
REQ-022 In FIFO_STD mode, an accepted read SHALL load rd_data at the next clock edge and pulse rd_valid high for exactly that one cycle.
REQ-023 In FIFO_STD mode, rd_data SHALL hold its value when no read is accepted.
REQ-024 On flush, pointers and occup SHALL be zeroed at the next edge; flush overrides wr_en/rd_en in the same cycle.
REQ-025 Flush SHALL NOT alter memory contents, sticky flags or a FIFO_STD rd_data already loaded.
REQ-026 In FIFO_STD mode, flush SHALL force rd_valid low for the following cycle.
REQ-027 overflow SHALL set on wr_en && !wr_acc && !flush, and underflow SHALL set on rd_en && !rd_acc && !flush.
REQ-028 Both sticky flags SHALL clear on err_clr, and a set SHALL win over err_clr in the same cycle.
REQ-029 Illegal parameter combinations SHALL cause an elaboration-time $error.

Reset
REQ-030 Asserting rst_n low SHALL immediately force: empty=1, full=0, almost_empty=1, almost_full=0, occup=0, overflow=0, underflow=0, rd_valid=0, rd_data=0 (FIFO_STD), and pointers=0.
REQ-031 Storage memory SHALL NOT be reset, and reads of unwritten entries SHALL be impossible, since empty=1.
REQ-032 Reset asserted mid-operation SHALL discard all contents, and the first write after deassertion SHALL land at entry 0.

Structure
REQ-033 Package fifo_pkg SHALL hold typedef enum fifo_mode_e {FIFO_FWFT, FIFO_STD}, shared by all FIFO variants.
REQ-034 Sub-module fifo_ptr_mod SHALL implement a modulo-DEPTH pointer counter with an increment and synchronous clear, instantiated once each for the write and read pointers.
REQ-035 The memory SHALL be a flip-flop array with no RAM macro.

Verification
REQ-036 DEPTH=5, FWFT: write 5 words 0xA0..0xA4 -> full=1 and almost_full=1 at occup 3; a 6th write -> overflow=1, contents unchanged; 5 reads return 0xA0..0xA4 in order, then empty=1.
REQ-037 DEPTH=5, full, wr_en and rd_en held together for 7 cycles -> occup stays 5, no overflow, and the pointers wrap correctly, with output order preserved across the wrap.
REQ-038 FIFO_STD, one word 0x55 written, rd_en pulsed -> rd_valid=1 and rd_data=0x55 exactly one cycle later; a further rd_en while empty -> underflow=1 and rd_valid stays 0.
REQ-039 3 entries present, flush together with wr_en and rd_en -> next cycle occup=0 and empty=1, no error flags; the next write+read returns the new word.
REQ-040 overflow set, then err_clr asserted in the same cycle as a new overflowing write -> overflow stays 1; err_clr alone in the next cycle -> overflow=0.
REQ-041 Asynchronous rst_n assertion between clock edges with 4 entries present -> all outputs take reset values before the next edge, and the first post-reset write reads back correctly.
